// File: rtl/bpf_core_dispatcher_if.sv
// Descriptor-in / verdict-out handshake bundle for bpf_core_dispatcher.
// The out_timeout signal exists only when BPF_DISPATCH_TIMEOUT_EN is defined.
interface bpf_core_dispatcher_if #(
  parameter int BUF_ID_WIDTH = 3,
  parameter int PLEN_WIDTH   = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic [BUF_ID_WIDTH-1:0] in_buf_id;
  logic [PLEN_WIDTH-1:0]   in_len;
  logic                    out_valid;
  logic                    out_ready;
  logic [BUF_ID_WIDTH-1:0] out_buf_id;
  logic [PLEN_WIDTH-1:0]   out_len;
  logic                    out_acc;
  logic [2:0]              out_core;
`ifdef BPF_DISPATCH_TIMEOUT_EN
  logic                    out_timeout;
`endif

  modport master (
    output in_valid, in_buf_id, in_len, out_ready,
    input  in_ready, out_valid, out_buf_id, out_len, out_acc, out_core
`ifdef BPF_DISPATCH_TIMEOUT_EN
    , input out_timeout
`endif
  );

  modport slave (
    input  in_valid, in_buf_id, in_len, out_ready,
    output in_ready, out_valid, out_buf_id, out_len, out_acc, out_core
`ifdef BPF_DISPATCH_TIMEOUT_EN
    , output out_timeout
`endif
  );
endinterface

// File: rtl/bpf_core_dispatcher.sv
// Round-robin dispatcher sharing NUM_CORES BPF cores; per-core IDLE/RUN/DONE FSM.
// Optional per-run watchdog enabled by defining BPF_DISPATCH_TIMEOUT_EN.
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | core free, may receive the next descriptor
// ST_RUN  | core_go high, waiting for acc/rej (or watchdog)
// ST_DONE | verdict latched, waiting for forwarder handshake
module bpf_core_dispatcher #(
  parameter int NUM_CORES      = 4,
  parameter int BUF_ID_WIDTH   = 3,
  parameter int PLEN_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            rst_n,
  bpf_core_dispatcher_if.slave            bus,
  output logic [NUM_CORES-1:0]            core_go_o,
  output logic [NUM_CORES*PLEN_WIDTH-1:0] core_len_o,
  input  logic [NUM_CORES-1:0]            core_acc_i,
  input  logic [NUM_CORES-1:0]            core_rej_i,
  output logic [3:0]                      busy_count_o
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} core_st_e;

  core_st_e                st_q  [NUM_CORES];
  core_st_e                st_d  [NUM_CORES];
  logic [BUF_ID_WIDTH-1:0] id_q  [NUM_CORES];
  logic [BUF_ID_WIDTH-1:0] id_d  [NUM_CORES];
  logic [PLEN_WIDTH-1:0]   len_q [NUM_CORES];
  logic [PLEN_WIDTH-1:0]   len_d [NUM_CORES];
  logic [NUM_CORES-1:0]    acc_q, acc_d;
  logic [NUM_CORES-1:0]    go_q, go_d;
  logic [2:0]              dp_q, dp_d;
  logic [2:0]              rp_q, rp_d;
  logic [3:0]              busy_q, busy_d;

  logic [2:0]              disp_sel, res_sel;
  logic                    disp_hit, res_hit;
  logic                    disp_fire, res_fire;

`ifdef BPF_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]        cnt_q [NUM_CORES];
  logic [CNT_W-1:0]        cnt_d [NUM_CORES];
  logic [NUM_CORES-1:0]    to_q, to_d;
`endif

  function automatic logic [2:0] wrap_inc(input logic [2:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_CORES) s = s - NUM_CORES;
    return 3'(s);
  endfunction

  // First IDLE core at/after dp and first DONE core at/after rp.
  always_comb begin
    disp_sel = '0;
    res_sel  = '0;
    disp_hit = 1'b0;
    res_hit  = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!disp_hit && st_q[i] == ST_IDLE && wrap_inc(dp_q, k) == 3'(i)) begin
          disp_hit = 1'b1;
          disp_sel = 3'(i);
        end
        if (!res_hit && st_q[i] == ST_DONE && wrap_inc(rp_q, k) == 3'(i)) begin
          res_hit = 1'b1;
          res_sel = 3'(i);
        end
      end
    end
  end

  always_comb begin
    bus.in_ready   = disp_hit;
    bus.out_valid  = res_hit;
    bus.out_core   = res_sel;
    bus.out_buf_id = '0;
    bus.out_len    = '0;
    bus.out_acc    = 1'b0;
`ifdef BPF_DISPATCH_TIMEOUT_EN
    bus.out_timeout = 1'b0;
`endif
    core_len_o     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_len_o[i*PLEN_WIDTH +: PLEN_WIDTH] = len_q[i];
      if (res_hit && res_sel == 3'(i)) begin
        bus.out_buf_id = id_q[i];
        bus.out_len    = len_q[i];
        bus.out_acc    = acc_q[i];
`ifdef BPF_DISPATCH_TIMEOUT_EN
        bus.out_timeout = to_q[i];
`endif
      end
    end
  end

  assign core_go_o    = go_q;
  assign busy_count_o = busy_q;

  always_comb begin
    disp_fire = bus.in_valid && disp_hit;
    res_fire  = bus.out_ready && res_hit;
    dp_d      = disp_fire ? wrap_inc(disp_sel, 1) : dp_q;
    // While a verdict is stalled, park rp on it so a later finisher cannot displace it.
    rp_d      = res_fire ? wrap_inc(res_sel, 1) : (res_hit ? res_sel : rp_q);
    busy_d    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      st_d[i]  = st_q[i];
      id_d[i]  = id_q[i];
      len_d[i] = len_q[i];
      acc_d[i] = acc_q[i];
`ifdef BPF_DISPATCH_TIMEOUT_EN
      cnt_d[i] = cnt_q[i];
      to_d[i]  = to_q[i];
`endif
      case (st_q[i])
        ST_IDLE: begin
          if (disp_fire && disp_sel == 3'(i)) begin
            st_d[i]  = ST_RUN;
            id_d[i]  = bus.in_buf_id;
            len_d[i] = bus.in_len;
`ifdef BPF_DISPATCH_TIMEOUT_EN
            cnt_d[i] = '0;
`endif
          end
        end
        ST_RUN: begin
          if (core_acc_i[i] || core_rej_i[i]) begin
            st_d[i]  = ST_DONE;
            acc_d[i] = core_acc_i[i] && !core_rej_i[i];
`ifdef BPF_DISPATCH_TIMEOUT_EN
            to_d[i]  = 1'b0;
`endif
          end
`ifdef BPF_DISPATCH_TIMEOUT_EN
          else if (cnt_q[i] == TO_LAST) begin
            st_d[i]  = ST_DONE;
            acc_d[i] = 1'b0;
            to_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          if (res_fire && res_sel == 3'(i)) st_d[i] = ST_IDLE;
        end
        default: st_d[i] = ST_IDLE;
      endcase
      go_d[i] = (st_d[i] == ST_RUN);
      if (st_d[i] != ST_IDLE) busy_d = busy_d + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_q   <= '0;
      rp_q   <= '0;
      busy_q <= '0;
      go_q   <= '0;
      acc_q  <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        st_q[i]  <= ST_IDLE;
        id_q[i]  <= '0;
        len_q[i] <= '0;
      end
`ifdef BPF_DISPATCH_TIMEOUT_EN
      to_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= '0;
`endif
    end else begin
      dp_q   <= dp_d;
      rp_q   <= rp_d;
      busy_q <= busy_d;
      go_q   <= go_d;
      acc_q  <= acc_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        st_q[i]  <= st_d[i];
        id_q[i]  <= id_d[i];
        len_q[i] <= len_d[i];
      end
`ifdef BPF_DISPATCH_TIMEOUT_EN
      to_q <= to_d;
      for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= cnt_d[i];
`endif
    end
  end
endmodule

// File: doc/bpf_core_dispatcher.md
Name: bpf_core_dispatcher

Overview:
- Shares a pool of NUM_CORES BPF CPU cores among packets that the snooper-side buffer pool has finished filling.
- Accepts packet descriptors (buffer id and length) and assigns each to an idle core, round-robin.
- Sequences that core's run by holding its mem_ready-style go line high, then captures the accept/reject verdict.
- Offers verdicts to the forwarder over a valid/ready handshake, with round-robin ordering among finished cores.

Parameters:
NUM_CORES, 4, number of CPU cores managed (2..8)
BUF_ID_WIDTH, 3, width of packet buffer identifier
PLEN_WIDTH, 10, width of packet length in bytes
TIMEOUT_CYCLES, 4096, watchdog limit per run (used only with BPF_DISPATCH_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid&&in_ready at posedge
in_buf_id  in  BUF_ID_WIDTH  buffer holding the packet
in_len  in  PLEN_WIDTH  packet length
core_go  out  NUM_CORES  per-core run enable; drives the core's mem_ready
core_len  out  NUM_CORES*PLEN_WIDTH  per-core latched length; core i uses bits [i*PLEN_WIDTH +: PLEN_WIDTH]
core_acc  in  NUM_CORES  per-core accept pulse
core_rej  in  NUM_CORES  per-core reject pulse
out_valid  out  1  verdict available
out_ready  in  1  forwarder consumes verdict
out_buf_id  out  BUF_ID_WIDTH  buffer the verdict belongs to
out_len  out  PLEN_WIDTH  packet length
out_acc  out  1  1=accept (forward), 0=reject (drop)
out_core  out  3  index of the core that produced the verdict
busy_count  out  4  number of cores not IDLE

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: all cores IDLE, both round-robin pointers 0, core_go=0, core_len=0, in_ready=1, out_valid=0, busy_count=0.
- Per-core FSM has three states: IDLE -> RUNNING -> DONE -> IDLE.
- Dispatch:
  - in_ready = any core IDLE, computed from registered state only.
  - On handshake, select the first IDLE core at or after dispatch pointer dp, wrapping modulo NUM_CORES.
  - That core latches buf_id/len and goes RUNNING; dp <- selected+1 (wrapping).
- core_go[i] is a registered output, high exactly while core i is RUNNING. It rises the cycle after the handshake (1-cycle latency).
- Completion, RUNNING core only:
  - core_acc or core_rej sampled high -> latch verdict (acc=core_acc&&!core_rej; reject wins on simultaneous pulses) -> DONE.
  - core_go falls the next cycle.
- acc/rej pulses on a core that is not RUNNING are ignored.
- Result:
  - out_valid = any core DONE, from registered state.
  - out_* are muxed combinationally from the first DONE core at or after result pointer rp.
  - out_* stay stable while out_valid && !out_ready.
  - On handshake, that core goes IDLE and rp <- core+1 (wrapping).
- Turnaround: a core leaving DONE this cycle is not dispatchable this cycle; it is dispatchable next cycle. core_go is therefore low for at least 2 cycles between runs, which guarantees the core's reset.
- Simultaneous events are legal in the same cycle on different cores: dispatch to one core, completion on another, result handshake on a third.
- busy_count is registered and reflects state after each edge.
- Reset mid-run: all cores return to IDLE; in-flight descriptors and verdicts are discarded; core_go drops asynchronously.

Optional Feature:
Macro: BPF_DISPATCH_TIMEOUT_EN
- Defined:
  - Each core has a counter cleared on dispatch and incremented while RUNNING.
  - When it reaches TIMEOUT_CYCLES-1 without acc/rej, the core goes DONE with out_acc=0.
  - Extra output port out_timeout (1 bit) is valid with out_valid; 1 only for watchdog verdicts.
  - A genuine acc/rej on the same cycle as expiry wins, with out_timeout=0.
- Undefined: no counters and no out_timeout port; a core that never finishes stays RUNNING indefinitely.

Test Plan:
- Reset, then in_valid with buf_id=5, len=64 -> in_ready=1; core_go=4'b0001 next cycle; core_len[0]=64; busy_count=1.
- Core 0 pulses acc for 1 cycle -> next cycle out_valid=1, out_buf_id=5, out_acc=1, out_core=0, core_go=0; out_ready -> out_valid=0, busy_count=0.
- Five descriptors back-to-back with all cores running -> ids 0..3 accepted into cores 0,1,2,3; in_ready=0 holding the 5th; after core 2 rejects and its verdict is consumed, the 5th goes to core 2 two cycles later.
- Cores 1 and 3 pulse acc/rej in the same cycle with rp=2, out_ready held 0 for 3 cycles -> core 3's verdict is presented and stable; then core 1's; core 1 (acc=1, rej=1) reports out_acc=0.
- acc pulse on an IDLE core -> no state change; out_valid stays 0.
- Async rst_n low mid-run with 3 cores RUNNING -> core_go=0 immediately; after release in_ready=1 and busy_count=0. With BPF_DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=16: a silent core yields out_acc=0, out_timeout=1, 16 cycles after dispatch.
